// File: rtl/oam_dma_ctrl.sv
// OAM sprite DMA controller: a CPU write to $4014 halts the CPU and copies one
// 256-byte page of CPU memory into OAM, starting at the sampled OAMADDR.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_cpu,
    input  logic [7:0]  data_cpu,
    input  logic        RWE,
    input  logic [7:0]  oam_addr_start,
    input  logic [7:0]  mem_data_out,
    output logic [15:0] dma_address,
    output logic        dma_read,
    output logic        cpu_halt,
    output logic        oam_we,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] idx_r;
    logic [7:0] page_r;
    logic [7:0] base_r;
    logic       parity_r;
    logic       done_r;
    logic       trigger_s;
    logic       last_write_s;

    // Only an idle controller accepts a $4014 write; later writes are dropped.
    assign trigger_s    = RWE && (address_cpu == 16'h4014) && (state_r == ST_IDLE);
    assign last_write_s = (state_r == ST_WRITE) && (idx_r == 8'hFF);

    // State, transfer context, free-running cycle parity and completion flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            idx_r    <= 8'd0;
            page_r   <= 8'd0;
            base_r   <= 8'd0;
            parity_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            parity_r <= ~parity_r;
            done_r   <= last_write_s;
            if (trigger_s) begin
                page_r <= data_cpu;
                base_r <= oam_addr_start;
                idx_r  <= 8'd0;
            end else if (state_r == ST_WRITE) begin
                idx_r <= idx_r + 8'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_s     = state_r;
        dma_read    = 1'b0;
        dma_address = 16'h0000;
        oam_we      = 1'b0;
        oam_address = 8'h00;
        oam_data    = 8'h00;
        cpu_halt    = 1'b1;
        dma_busy    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                cpu_halt = 1'b0;
                dma_busy = 1'b0;
                if (trigger_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                // An odd halt cycle needs one extra cycle to land reads on the right phase.
                if (parity_r) begin
                    state_s = ST_ALIGN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_ALIGN: begin
                state_s = ST_READ;
            end
            ST_READ: begin
                dma_read    = 1'b1;
                dma_address = {page_r, idx_r};
                state_s     = ST_WRITE;
            end
            ST_WRITE: begin
                oam_we      = 1'b1;
                oam_address = base_r + idx_r;
                oam_data    = mem_data_out;
                if (idx_r == 8'hFF) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cpu_halt = 1'b0;
                dma_busy = 1'b0;
            end
        endcase
    end

    assign dma_done = done_r;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a memory model feeds reads, and a scoreboard
// of expected read addresses and OAM writes is checked as the DUT produces them.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_cpu;
    logic [7:0]  data_cpu;
    logic        RWE;
    logic [7:0]  oam_addr_start;
    logic [7:0]  mem_data_out;
    logic [15:0] dma_address;
    logic        dma_read;
    logic        cpu_halt;
    logic        oam_we;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;
    logic        dma_busy;
    logic        dma_done;

    oam_dma_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .address_cpu    (address_cpu),
        .data_cpu       (data_cpu),
        .RWE            (RWE),
        .oam_addr_start (oam_addr_start),
        .mem_data_out   (mem_data_out),
        .dma_address    (dma_address),
        .dma_read       (dma_read),
        .cpu_halt       (cpu_halt),
        .oam_we         (oam_we),
        .oam_address    (oam_address),
        .oam_data       (oam_data),
        .dma_busy       (dma_busy),
        .dma_done       (dma_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic        tp;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] rd_q [$];
    logic [15:0] wr_q [$];
    int          halt_cnt;
    int          done_cnt;
    int          first_rd;
    logic        prev_we = 1'b0;

    // Memory answers a read one cycle later.
    always @(posedge clk) begin
        mem_data_out <= dma_read ? mem[dma_address] : 8'h00;
    end

    // Expected cycle parity: cleared by reset, toggles every clock.
    always @(posedge clk) begin
        tp <= reset ? 1'b0 : ~tp;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [15:0] e;
        @(negedge clk);
        if (dma_read) begin
            if (rd_q.size() == 0) begin
                chk("spurious_dma_read", 32'(dma_read), 32'd0);
            end else begin
                e = rd_q.pop_front();
                chk("dma_address", 32'(dma_address), 32'(e));
            end
        end else begin
            chk("dma_address_idle", 32'(dma_address), 32'd0);
        end
        if (oam_we) begin
            chk("oam_we_back_to_back", 32'(prev_we), 32'd0);
            if (wr_q.size() == 0) begin
                chk("spurious_oam_we", 32'(oam_we), 32'd0);
            end else begin
                e = wr_q.pop_front();
                chk("oam_write", 32'({oam_address, oam_data}), 32'(e));
            end
        end
        prev_we = oam_we;
        if (cpu_halt) begin
            if (dma_read && first_rd < 0) first_rd = halt_cnt;
            halt_cnt++;
        end
        if (dma_done) begin
            done_cnt++;
            chk("done_while_idle", 32'(dma_busy), 32'd0);
        end
        chk("halt_eq_busy", 32'(cpu_halt), 32'(dma_busy));
    endtask

    // want_par: parity of the HALT cycle (0/1), or -1 to trigger right away.
    task automatic run_xfer(input logic [7:0] page, input logic [7:0] base,
                            input int want_par, input int inject_at, input int abort_at);
        int   k;
        int   guard;
        int   par_eff;
        guard = 0;
        if (want_par >= 0) begin
            while ((tp == want_par[0]) && guard < 4) begin
                cycle();
                guard++;
            end
        end
        par_eff = tp ? 0 : 1;
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({page, 8'(i)});
            wr_q.push_back({8'(base + 8'(i)), mem[{page, 8'(i)}]});
        end
        halt_cnt = 0;
        done_cnt = 0;
        first_rd = -1;
        address_cpu    = 16'h4014;
        data_cpu       = page;
        oam_addr_start = base;
        RWE            = 1'b1;
        cycle();
        RWE = 1'b0; address_cpu = 16'h0000; data_cpu = 8'h00;
        chk("busy_after_trigger", 32'(dma_busy), 32'd1);
        k = 0;
        while (dma_busy && k < 700) begin
            if (k == inject_at) begin
                RWE = 1'b1; address_cpu = 16'h4014; data_cpu = 8'h07;
            end
            if (k == abort_at) reset = 1'b1;
            cycle();
            RWE = 1'b0; address_cpu = 16'h0000; data_cpu = 8'h00; reset = 1'b0;
            k++;
        end
        chk("xfer_timeout", 32'(k < 700), 32'd1);
        if (abort_at >= 0) begin
            chk("abort_halt", 32'(cpu_halt), 32'd0);
            chk("abort_we", 32'(oam_we), 32'd0);
            chk("abort_done", 32'(dma_done), 32'd0);
            chk("abort_partial", 32'(wr_q.size() > 0 && wr_q.size() < 256), 32'd1);
            rd_q.delete();
            wr_q.delete();
            repeat (4) cycle();
            chk("abort_done_count", 32'(done_cnt), 32'd0);
        end else begin
            chk("done_pulse", 32'(dma_done), 32'd1);
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("halt_cycles", 32'(halt_cnt), 32'(513 + par_eff));
            chk("first_read", 32'(first_rd), 32'(1 + par_eff));
            chk("reads_left", 32'(rd_q.size()), 32'd0);
            chk("writes_left", 32'(wr_q.size()), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; RWE = 1'b0; address_cpu = 16'h0000; data_cpu = 8'h00;
        oam_addr_start = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i);
            mem[16'h0300 + i] = ~8'(i);
            mem[16'hFF00 + i] = 8'(i) ^ 8'h5A;
        end
        cycle();
        cycle();
        chk("rst_busy", 32'(dma_busy), 32'd0);
        chk("rst_halt", 32'(cpu_halt), 32'd0);
        chk("rst_read", 32'(dma_read), 32'd0);
        chk("rst_we", 32'(oam_we), 32'd0);
        chk("rst_done", 32'(dma_done), 32'd0);
        chk("rst_oam_addr", 32'({oam_address, oam_data}), 32'd0);
        reset = 1'b0;
        cycle();

        // Non-triggering writes and reset priority.
        RWE = 1'b1; address_cpu = 16'h4015; data_cpu = 8'h02;
        cycle();
        RWE = 1'b0; address_cpu = 16'h4014;
        chk("no_trig_other_addr", 32'(dma_busy), 32'd0);
        cycle();
        chk("no_trig_rwe_low", 32'(dma_busy), 32'd0);
        reset = 1'b1; RWE = 1'b1;
        cycle();
        reset = 1'b0; RWE = 1'b0; address_cpu = 16'h0000; data_cpu = 8'h00;
        chk("reset_beats_trigger", 32'(dma_busy), 32'd0);
        cycle();

        run_xfer(8'h02, 8'h00, 0, -1, -1);
        cycle();
        run_xfer(8'h02, 8'h00, 1, -1, -1);
        // Back-to-back: triggers in the dma_done cycle of the previous transfer.
        run_xfer(8'h03, 8'hFC, -1, -1, -1);
        cycle();
        run_xfer(8'h02, 8'h00, -1, 100, -1);
        cycle();
        run_xfer(8'h02, 8'h00, -1, -1, 200);
        run_xfer(8'hFF, 8'h00, 0, -1, -1);
        cycle();
        chk("final_idle", 32'(dma_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
